// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: out = neg ? -in : in.
module muldiv_negate #(
   parameter int W = 32
) (
   input  logic         neg_i,
   input  logic [W-1:0] in_i,
   output logic [W-1:0] out_o
);

   assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; magnitude datapath,
// one shift-add or restoring step per cycle, sign correction in a final cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = muldiv_pkg::WIDTH,
   parameter int CNT_W = muldiv_pkg::CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mop_q, mop_d;      // multiplicand for MUL, divisor for DIV
   logic [WIDTH-1:0]     araw_q, araw_d;
   logic                 neg_q, neg_d;
   logic                 rsign_q, rsign_d;
   logic                 bz_q, bz_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic                 done_q, done_d, dbz_q, dbz_d;

   logic                 sgn_op, sa, sb;
   logic [WIDTH-1:0]     a_abs, b_abs, quo_fix, rem_fix;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH:0]       mul_sum, div_trial;
   logic [2*WIDTH-1:0]   mul_nxt, div_nxt;

   assign sgn_op = ~op_i[0];
   assign sa     = sgn_op & a_i[WIDTH-1];
   assign sb     = sgn_op & b_i[WIDTH-1];

   muldiv_negate #(.W(WIDTH))   u_abs_a (.neg_i(sa),      .in_i(a_i),                  .out_o(a_abs));
   muldiv_negate #(.W(WIDTH))   u_abs_b (.neg_i(sb),      .in_i(b_i),                  .out_o(b_abs));
   muldiv_negate #(.W(2*WIDTH)) u_fix_p (.neg_i(neg_q),   .in_i(acc_q),                .out_o(prod_fix));
   muldiv_negate #(.W(WIDTH))   u_fix_q (.neg_i(neg_q),   .in_i(acc_q[WIDTH-1:0]),     .out_o(quo_fix));
   muldiv_negate #(.W(WIDTH))   u_fix_r (.neg_i(rsign_q), .in_i(acc_q[2*WIDTH-1:WIDTH]), .out_o(rem_fix));

   // MUL: acc = {partial product, remaining multiplier bits}, shifted right each step.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mop_q};
   assign mul_nxt = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

   // DIV: acc = {remainder, dividend/quotient}, shifted left each step.
   assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mop_q};
   assign div_nxt   = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mop_d   = mop_q;
      araw_d  = araw_q;
      neg_d   = neg_q;
      rsign_d = rsign_q;
      bz_d    = bz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hi_we_i) hi_d = wdata_i;
            if (lo_we_i) lo_d = wdata_i;
            if (start_i) begin
               op_d    = op_e'(op_i);
               cnt_d   = CNT_W'(WIDTH);
               araw_d  = a_i;
               neg_d   = sa ^ sb;
               rsign_d = sa;
               bz_d    = (b_i == '0);
               acc_d   = op_i[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
               mop_d   = op_i[1] ? b_abs : a_abs;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d = op_q[1] ? div_nxt : mul_nxt;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!flush_i) begin
               done_d = 1'b1;
               if (!op_q[1]) begin
                  {hi_d, lo_d} = prod_fix;
               end else if (bz_q) begin
                  hi_d  = araw_q;
                  lo_d  = '1;
                  dbz_d = 1'b1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         op_q    <= OP_MULT;
         cnt_q   <= '0;
         acc_q   <= '0;
         mop_q   <= '0;
         araw_q  <= '0;
         neg_q   <= 1'b0;
         rsign_q <= 1'b0;
         bz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mop_q   <= mop_d;
         araw_q  <= araw_d;
         neg_q   <= neg_d;
         rsign_q <= rsign_d;
         bz_q    <= bz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic/timing reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, flush, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done, dbz;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;

   muldiv_unit dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .flush_i(flush), .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
      .busy_o(busy), .done_o(done), .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
   );

   always #5 clk = ~clk;

   // Reference result {div_by_zero, HI, LO} from plain arithmetic.
   function automatic logic [64:0] model_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      longint sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'd0: p = 64'(sx * sy);
         2'd1: p = {32'b0, x} * {32'b0, y};
         2'd2: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
         default: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      endcase
      return {o[1] && (y == 0), p};
   endfunction

   // Timing model: an accepted op completes 33 edges later unless flushed.
   int          m_cnt;
   logic [31:0] m_hi, m_lo;
   logic        m_done, m_dbz;
   logic [64:0] m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_hi   <= 0;
         m_lo   <= 0;
         m_done <= 0;
         m_dbz  <= 0;
         m_pend <= 0;
      end else begin
         m_done <= 0;
         m_dbz  <= 0;
         if (m_cnt > 0) begin
            if (flush) m_cnt <= 0;
            else begin
               m_cnt <= m_cnt - 1;
               if (m_cnt == 1) begin
                  m_hi   <= m_pend[63:32];
                  m_lo   <= m_pend[31:0];
                  m_done <= 1;
                  m_dbz  <= m_pend[64];
               end
            end
         end else begin
            if (hi_we) m_hi <= wdata;
            if (lo_we) m_lo <= wdata;
            if (start) begin
               m_pend <= model_res(op, a, b);
               m_cnt  <= 33;
            end
         end
      end
   end

   always @(negedge clk) begin
      vectors++;
      if ({busy, done, dbz, hi, lo} !== {(m_cnt != 0), m_done, m_dbz, m_hi, m_lo}) begin
         miscompares++;
         $display("FAIL cycle@%0t: got busy=%b done=%b dbz=%b hi=%h lo=%h, want busy=%b done=%b dbz=%b hi=%h lo=%h",
                  $time, busy, done, dbz, hi, lo, (m_cnt != 0), m_done, m_dbz, m_hi, m_lo);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Called at a negedge; launches an op and returns at the negedge inside the done cycle.
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic ez);
      int k = 0;
      start = 1; op = o; a = x; b = y;
      do begin
         @(negedge clk);
         start = 0;
         k++;
      end while (!done && k < 50);
      chk({name, " latency"}, k, 34);
      chk({name, " done"}, {31'b0, done}, 1);
      chk({name, " dbz"}, {31'b0, dbz}, {31'b0, ez});
      chk({name, " hi"}, hi, eh);
      chk({name, " lo"}, lo, el);
   endtask

   initial begin
      int seen;
      rst_n = 0; start = 0; flush = 0; hi_we = 0; lo_we = 0;
      op = 0; a = 0; b = 0; wdata = 0;
      repeat (2) @(negedge clk);
      chk("reset busy", {31'b0, busy}, 0);
      chk("reset hi", hi, 0);
      chk("reset lo", lo, 0);
      rst_n = 1;
      @(negedge clk);

      run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
      run_op("mult_neg",  2'd0, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
      run_op("divu_b2b",  2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 0);
      run_op("div_neg",   2'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
      run_op("div_zero",  2'd2, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1);
      @(negedge clk);
      chk("dbz one cycle", {31'b0, dbz}, 0);

      // MTHI/MTLO, then a flushed divide with a stray MTHI while busy.
      hi_we = 1; lo_we = 1; wdata = 32'hAAAA_5555;
      @(negedge clk);
      hi_we = 0; lo_we = 0;
      chk("mthi", hi, 32'hAAAA_5555);
      chk("mtlo", lo, 32'hAAAA_5555);
      start = 1; op = 2'd2; a = 32'd100; b = 32'd7;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 0;
         hi_we = (k == 3);
         wdata = 32'h1234_5678;
         flush = (k == 10);
      end
      @(negedge clk);
      flush = 0; hi_we = 0;
      chk("flush busy", {31'b0, busy}, 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("flush no done", seen, 0);
      chk("flush hi kept", hi, 32'hAAAA_5555);

      // Asynchronous reset mid-RUN.
      start = 1; op = 2'd1; a = 32'd5; b = 32'd7;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst busy", {31'b0, busy}, 0);
      chk("arst done", {31'b0, done}, 0);
      chk("arst hi", hi, 0);
      chk("arst lo", lo, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      run_op("multu_small", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
